// File: rtl/hier_bus_serializer.sv
// Round-robin multi-channel serializer: one DATA_W word per grant, sent LSB-first as LINK_W beats.
// Optional HIER_SER_PARITY_EN adds a registered even-parity bit per beat on link_parity.
module hier_bus_serializer #(
    parameter int DATA_W   = 900,
    parameter int LINK_W   = 30,
    parameter int CHANNELS = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          in_valid,
    output logic [CHANNELS-1:0]          in_ready,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    output logic                         link_valid,
    input  logic                         link_ready,
    output logic [LINK_W-1:0]            link_data,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] link_ch,
    output logic                         link_first,
    output logic                         link_last,
    output logic                         link_parity
);
    localparam int BEATS  = (DATA_W + LINK_W - 1) / LINK_W;
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PAD_W  = BEATS * LINK_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(CHANNELS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             r_state, w_state_nxt;
    logic [CH_W-1:0]    r_rr, r_ch, w_grant;
    logic [BEAT_W-1:0]  r_beat;
    logic [PAD_W-1:0]   r_word, w_word_nxt, w_load;
    logic               w_any, w_last, w_hs, w_last_hs, w_win, w_accept;

    // Scan from the round-robin pointer; the first requester found wins.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!w_any && in_valid[(int'(r_rr) + i) % CHANNELS]) begin
                w_any   = 1'b1;
                w_grant = CH_W'((int'(r_rr) + i) % CHANNELS);
            end
        end
    end

    assign w_last    = (r_beat == LAST_BEAT);
    assign w_hs      = (r_state == SEND) && link_ready;
    assign w_last_hs = w_hs && w_last;
    assign w_win     = (r_state == IDLE) || w_last_hs;
    // Never accept during reset: the word would be dropped while the source thinks it was taken.
    assign w_accept  = w_win && w_any && !reset;
    assign in_ready  = w_accept ? (CHANNELS'(1) << w_grant) : '0;

    // Zero-extended so the final beat carries zeros above DATA_W.
    assign w_load = PAD_W'(in_data[int'(w_grant)*DATA_W +: DATA_W]);

    always_comb begin
        w_word_nxt = r_word;
        if (w_accept)
            w_word_nxt = w_load;
        else if (w_hs)
            w_word_nxt = r_word >> LINK_W;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = SEND;
            SEND: if (w_last_hs) w_state_nxt = w_accept ? SEND : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_rr    <= '0;
            r_ch    <= '0;
            r_beat  <= '0;
            r_word  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_word  <= w_word_nxt;
            if (w_accept) begin
                r_ch   <= w_grant;
                r_beat <= '0;
                r_rr   <= (w_grant == LAST_CH) ? '0 : w_grant + 1'b1;
            end else if (w_hs) begin
                r_beat <= w_last ? '0 : r_beat + 1'b1;
            end
        end
    end

    assign link_valid = (r_state == SEND);
    assign link_data  = r_word[LINK_W-1:0];
    assign link_ch    = r_ch;
    assign link_first = (r_state == SEND) && (r_beat == '0);
    assign link_last  = (r_state == SEND) && w_last;

`ifdef HIER_SER_PARITY_EN
    logic r_par;
    always_ff @(posedge clk) begin
        if (reset)
            r_par <= 1'b0;
        else
            r_par <= (w_state_nxt == SEND) && (^w_word_nxt[LINK_W-1:0]);
    end
    assign link_parity = r_par;
`else
    assign link_parity = 1'b0;
`endif

endmodule

// File: tb/tb_hier_bus_serializer.sv
// Bench for hier_bus_serializer: directed steps plus random traffic against a transaction-level model.
module tb_hier_bus_serializer;
    localparam int DW = 900, LW = 30, CH = 2, BEATS = 30;
    typedef logic [DW-1:0] word_t;

    logic              clk = 1'b0, reset;
    logic [CH-1:0]     in_valid, in_ready;
    logic [CH*DW-1:0]  in_data;
    logic              link_valid, link_ready, link_first, link_last, link_parity;
    logic [LW-1:0]     link_data;
    logic [0:0]        link_ch;

    logic [0:0]        p_in_valid, p_in_ready, p_link_ch;
    logic [39:0]       p_in_data;
    logic              p_link_valid, p_link_ready, p_first, p_last, p_par;
    logic [29:0]       p_link_data;

    always #5 clk = ~clk;

    hier_bus_serializer #(.DATA_W(DW), .LINK_W(LW), .CHANNELS(CH)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .link_valid(link_valid), .link_ready(link_ready), .link_data(link_data), .link_ch(link_ch),
        .link_first(link_first), .link_last(link_last), .link_parity(link_parity));

    hier_bus_serializer #(.DATA_W(40), .LINK_W(30), .CHANNELS(1)) u_pad (
        .clk(clk), .reset(reset), .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data),
        .link_valid(p_link_valid), .link_ready(p_link_ready), .link_data(p_link_data), .link_ch(p_link_ch),
        .link_first(p_first), .link_last(p_last), .link_parity(p_par));

    int n_chk = 0, n_fail = 0;

    // Transaction model: sources, round-robin pointer, word in flight
    word_t q0[$], q1[$];
    logic [1:0] en;
    bit    busy;
    int    mch, mbeat, rrm;
    word_t mword;
    int    pulses[2];
    logic [7:0] ord;
    int    nord;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic word_t rnd_word();
        word_t w = '0;
        for (int i = 0; i < 29; i++) w = (w << 32) | word_t'($urandom);
        return w;
    endfunction

    function automatic word_t cnt_word();
        word_t w = '0;
        for (int k = 0; k < BEATS; k++) w[k*LW +: LW] = LW'(k + 1);
        return w;
    endfunction

    function automatic logic exp_par(input logic [LW-1:0] d);
`ifdef HIER_SER_PARITY_EN
        return ^d;
`else
        return 1'b0 & d[0];
`endif
    endfunction

    // One clock: drive inputs at posedge+1, check against the model, advance the model.
    task automatic cycle(input bit rdy);
        word_t sl;
        logic [1:0] xr;
        bit hs, lasths, win, found;
        int g;
        in_valid[0] = en[0] && (q0.size() > 0);
        in_valid[1] = en[1] && (q1.size() > 0);
        in_data = '0;
        if (q0.size() > 0) in_data[DW-1:0]    = q0[0];
        if (q1.size() > 0) in_data[2*DW-1:DW] = q1[0];
        link_ready = rdy;
        #1;
        chk("link_valid", 64'(link_valid), 64'(busy));
        if (busy) begin
            sl = mword >> (mbeat * LW);
            chk("link_data",  64'(link_data),  64'(sl[LW-1:0]));
            chk("link_ch",    64'(link_ch),    64'(mch));
            chk("link_first", 64'(link_first), 64'(mbeat == 0));
            chk("link_last",  64'(link_last),  64'(mbeat == BEATS - 1));
            chk("link_parity", 64'(link_parity), 64'(exp_par(sl[LW-1:0])));
        end else begin
            chk("link_parity_idle", 64'(link_parity), 64'(0));
        end
        hs     = busy && rdy;
        lasths = hs && (mbeat == BEATS - 1);
        win    = !busy || lasths;
        found  = 0;
        g      = 0;
        for (int i = 0; i < CH; i++)
            if (!found && in_valid[(rrm + i) % CH]) begin
                found = 1;
                g = (rrm + i) % CH;
            end
        xr = (win && found) ? (2'b01 << g) : 2'b00;
        chk("in_ready", 64'(in_ready), 64'(xr));
        if (in_ready[0]) pulses[0]++;
        if (in_ready[1]) pulses[1]++;
        if (hs) begin
            mbeat++;
            if (lasths) busy = 0;
        end
        if (xr != 0) begin
            busy  = 1;
            mch   = g;
            mbeat = 0;
            mword = (g == 0) ? q0.pop_front() : q1.pop_front();
            rrm   = (g + 1) % CH;
            ord   = {ord[6:0], 1'(g)};
            nord++;
        end
        @(posedge clk); #1;
    endtask

    task automatic drain(input int budget, input int stall_pct, output int n);
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || busy) && n < budget) begin
            cycle($urandom_range(0, 99) >= stall_pct);
            n++;
        end
        chk("drain_done", 64'(q0.size() + q1.size() + int'(busy)), 64'(0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = '0;
        link_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        busy = 0; rrm = 0; mbeat = 0;
        q0.delete(); q1.delete();
    endtask

    initial begin
        int n;
        logic [39:0] pw;
        reset = 1'b1; in_valid = '0; in_data = '0; link_ready = 1'b0; en = 2'b00;
        p_in_valid = '0; p_in_data = '0; p_link_ready = 1'b0;
        busy = 0; rrm = 0; mbeat = 0; mch = 0; mword = '0; ord = '0; nord = 0;
        pulses[0] = 0; pulses[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        // reset values
        chk("rst_link_valid", 64'(link_valid), 64'(0));
        chk("rst_link_data",  64'(link_data),  64'(0));
        chk("rst_link_ch",    64'(link_ch),    64'(0));
        chk("rst_first_last", 64'({link_first, link_last}), 64'(0));
        chk("rst_parity",     64'(link_parity), 64'(0));
        chk("rst_in_ready",   64'(in_ready),   64'(0));
        reset = 1'b0;

        // single word, slices 1..30
        q0.push_back(cnt_word()); en = 2'b01;
        drain(200, 0, n);
        chk("single_ready_pulses", 64'(pulses[0]), 64'(1));
        chk("single_cycles", 64'(n), 64'(1 + BEATS));

        // fairness and back-to-back from a fresh pointer
        do_reset();
        for (int i = 0; i < 2; i++) begin q0.push_back(rnd_word()); q1.push_back(rnd_word()); end
        en = 2'b11; nord = 0; ord = '0;
        drain(400, 0, n);
        chk("b2b_order", 64'(ord[3:0]), 64'(4'b0101));
        chk("b2b_cycles", 64'(n), 64'(1 + 4 * BEATS));

        // backpressure at beat 10
        q0.push_back(cnt_word()); en = 2'b01;
        for (int i = 0; i < 40 && !(busy && mbeat == 10); i++) cycle(1);
        chk("bp_reached_beat10", 64'(mbeat), 64'(10));
        repeat (5) begin
            cycle(0);
            chk("bp_hold_data", 64'(link_data), 64'(11));
        end
        cycle(1);
        chk("bp_next_beat", 64'(link_data), 64'(12));
        drain(200, 0, n);

        // reset in the middle of a ch1 word
        q1.push_back(rnd_word()); en = 2'b10;
        for (int i = 0; i < 40 && !(busy && mbeat == 15); i++) cycle(1);
        chk("rst_mid_reached", 64'(mbeat), 64'(15));
        do_reset();
        en = 2'b00;
        cycle(1);
        q0.push_back(rnd_word()); q1.push_back(rnd_word()); en = 2'b11; nord = 0;
        cycle(1);
        chk("post_rst_grant_ch0", 64'(ord[0]), 64'(0));
        chk("post_rst_grants", 64'(nord), 64'(1));
        drain(400, 0, n);

        // random traffic with random stalls
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(1, 4)) q0.push_back(rnd_word());
            repeat ($urandom_range(1, 4)) q1.push_back(rnd_word());
            en = 2'b11;
            drain(2000, 30, n);
        end

        // padding on the 40/30 instance
        pw = 40'hAB_CDEF_0123;
        p_in_valid = 1'b1; p_in_data = pw; p_link_ready = 1'b1;
        #1;
        chk("pad_in_ready", 64'(p_in_ready), 64'(1));
        @(posedge clk); #1;
        p_in_valid = 1'b0;
        chk("pad_b0_valid", 64'(p_link_valid), 64'(1));
        chk("pad_b0_data",  64'(p_link_data),  64'(pw[29:0]));
        chk("pad_b0_fl",    64'({p_first, p_last}), 64'(2'b10));
        @(posedge clk); #1;
        chk("pad_b1_data",  64'(p_link_data),  64'({20'b0, pw[39:30]}));
        chk("pad_b1_fl",    64'({p_first, p_last}), 64'(2'b01));
        @(posedge clk); #1;
        chk("pad_idle", 64'(p_link_valid), 64'(0));

        // parity: beat 7 then beat 3
        pw = 40'h00_C000_0007;
        p_in_valid = 1'b1; p_in_data = pw;
        @(posedge clk); #1;
        p_in_valid = 1'b0;
        chk("par_b0_data", 64'(p_link_data), 64'(7));
`ifdef HIER_SER_PARITY_EN
        chk("par_b0", 64'(p_par), 64'(1));
`else
        chk("par_b0", 64'(p_par), 64'(0));
`endif
        @(posedge clk); #1;
        chk("par_b1_data", 64'(p_link_data), 64'(3));
        chk("par_b1", 64'(p_par), 64'(0));
        @(posedge clk); #1;
        chk("par_idle", 64'(p_par), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
